tx_core: RTL and testbench

UART transmitter, the transmit-side counterpart of rx_core. It serialises one byte per request as start bit, 8 data bits LSB first, odd parity bit and 1 stop bit. Default rate is 19200 baud from a 100 MHz clock. It drives the serial line that rx_core samples, so the two blocks can be connected back-to-back for loopback testing.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/tx_core.sv | 118 +++++++++++
 tb/tb_tx_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default rates and bit-level helpers.
// Used by tx_core and rx_core.
package uart_pkg;

  localparam int unsigned CLK_FREQUENCY_DEF = 100_000_000;
  localparam int unsigned BAUD_RATE_DEF     = 19200;
  localparam int unsigned DATA_BITS         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and strobes bit_end_o during the last count.
// clear_i holds the count at zero so the next period starts aligned.
module uart_baud_gen #(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Strobe is registered one count ahead so it coincides with count LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= (cnt_d == LAST);
    end
  end

  assign bit_end_o = bit_end_q;

endmodule

// File: rtl/tx_core.sv
// UART transmitter: start, 8 data bits LSB first, odd parity, 1 stop bit.
// Optional TX_PARITY_INJECT_EN adds force_parity_err to invert the parity bit of one frame.
module tx_core import uart_pkg::*; #(
  parameter int unsigned CLK_FREQUENCY = CLK_FREQUENCY_DEF,
  parameter int unsigned BAUD_RATE     = BAUD_RATE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
`ifdef TX_PARITY_INJECT_EN
  input  logic                 force_parity_err,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tx_done_q;
  logic                 bit_end;
  logic                 parity_flip;

`ifdef TX_PARITY_INJECT_EN
  assign parity_flip = force_parity_err;
`else
  assign parity_flip = 1'b0;
`endif

  uart_baud_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == ST_IDLE),
    .bit_end_o(bit_end)
  );

  // Frame sequencer; tx, busy and tx_done all come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (send) begin
            shift_q   <= din;
            parity_q  <= odd_parity(din) ^ parity_flip;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_IDX) begin
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
            end else begin
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_tx_core.sv
// Directed bench for tx_core at a reduced bit period (BIT_CYCLES = 10, frame = 110 cycles).
// Frames are listed as 11-bit vectors, index 0 = start bit, 9 = parity, 10 = stop.
module tb_tx_core;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned BAUD   = 100;
  localparam int BC    = 10;
  localparam int FRAME = 11 * BC;
  localparam int HMAX  = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] din;
  logic       tx, busy, tx_done;
`ifdef TX_PARITY_INJECT_EN
  logic       force_parity_err;
`endif

  logic tx_h   [HMAX];
  logic busy_h [HMAX];
  logic done_h [HMAX];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_core #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .send            (send),
    .din             (din),
`ifdef TX_PARITY_INJECT_EN
    .force_parity_err(force_parity_err),
`endif
    .tx              (tx),
    .busy            (busy),
    .tx_done         (tx_done)
  );

  // Record n cycles at negedges; optionally pulse send at cycles s0/s1 and rst at r_at.
  task automatic watch(input int n, input int s0, input logic [7:0] d0,
                       input int s1, input logic [7:0] d1, input int r_at);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      tx_h[j]   = tx;
      busy_h[j] = busy;
      done_h[j] = tx_done;
      rst  = (j == r_at);
      send = (j == s0) || (j == s1);
      if (j == s0) din = d0;
      else if (j == s1) din = d1;
    end
    send = 1'b0;
    rst  = 1'b0;
  endtask

  function automatic logic exp_tx(input int j, input int s, input logic [10:0] f);
    if (j >= s && j < s + FRAME) return f[(j - s) / BC];
    return 1'b1;
  endfunction

  task automatic test_reset();
    int bad_tx, bad_busy, bad_done;
    rst = 1'b1; send = 1'b0; din = 8'h00;
`ifdef TX_PARITY_INJECT_EN
    force_parity_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (tx !== 1'b1)      begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    watch(1000, -1, 8'h00, -1, 8'h00, -1);
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int j = 0; j < 1000; j++) begin
      if (tx_h[j] !== 1'b1)   bad_tx++;
      if (busy_h[j] !== 1'b0) bad_busy++;
      if (done_h[j] !== 1'b0) bad_done++;
    end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL idle_tx: %0d cycles not high, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d busy cycles, expected 0", bad_busy); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL idle_done: %0d done cycles, expected 0", bad_done); end
    // rst and send together: reset must win, no frame starts.
    @(negedge clk);
    rst = 1'b1; send = 1'b1; din = 8'hA5;
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    watch(20, -1, 8'h00, -1, 8'h00, -1);
    bad_tx = 0;
    for (int j = 0; j < 20; j++) if (tx_h[j] !== 1'b1 || busy_h[j] !== 1'b0) bad_tx++;
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL rst_send_collision: %0d active cycles, expected 0", bad_tx); end
  endtask

  task automatic test_single();
    logic [10:0] f;
    int bad_tx, bad_busy, bad_done;
    f = 11'b11101001010;  // A5, parity 1
    watch(120, 0, 8'hA5, -1, 8'h00, -1);
    for (int k = 0; k < 11; k++) begin
      n_checks++;
      if (tx_h[1 + k*BC + BC/2] !== f[k]) begin
        n_fail++; $display("FAIL a5_midbit%0d: got %b expected %b", k, tx_h[1 + k*BC + BC/2], f[k]);
      end
    end
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int j = 0; j < 120; j++) begin
      if (tx_h[j] !== exp_tx(j, 1, f))        bad_tx++;
      if (busy_h[j] !== (j >= 1 && j <= FRAME)) bad_busy++;
      if (done_h[j] !== (j == FRAME + 1))     bad_done++;
    end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL a5_tx_cycles: %0d wrong cycles, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL a5_busy_window: %0d wrong cycles, expected 0", bad_busy); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL a5_done_pulse: %0d wrong cycles, expected 0", bad_done); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f0, f1;
    logic        e;
    int bad_tx, bad_busy, bad_done;
    f0 = 11'b11000000000;  // 00, parity 1
    f1 = 11'b11111111110;  // FF, parity 1 (eight ones)
    watch(230, 0, 8'h00, FRAME + 1, 8'hFF, -1);
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int j = 0; j < 230; j++) begin
      e = (j < FRAME + 2) ? exp_tx(j, 1, f0) : exp_tx(j, FRAME + 2, f1);
      if (tx_h[j] !== e) bad_tx++;
      if (busy_h[j] !== ((j >= 1 && j <= FRAME) || (j >= FRAME + 2 && j <= 2*FRAME + 1))) bad_busy++;
      if (done_h[j] !== (j == FRAME + 1 || j == 2*FRAME + 2)) bad_done++;
    end
    n_checks++; if (tx_h[FRAME + 1] !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_high: got %b expected 1", tx_h[FRAME + 1]); end
    n_checks++; if (tx_h[FRAME + 2] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got %b expected 0", tx_h[FRAME + 2]); end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL b2b_tx_cycles: %0d wrong cycles, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL b2b_busy_window: %0d wrong cycles, expected 0", bad_busy); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL b2b_done_pulses: %0d wrong cycles, expected 0", bad_done); end
  endtask

  task automatic test_send_while_busy();
    logic [10:0] f;
    int bad_tx, bad_busy, bad_done;
    f = 11'b11110000110;  // C3, parity 1
    watch(150, 0, 8'hC3, 40, 8'h3C, -1);
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int j = 0; j < 150; j++) begin
      if (tx_h[j] !== exp_tx(j, 1, f))        bad_tx++;
      if (busy_h[j] !== (j >= 1 && j <= FRAME)) bad_busy++;
      if (done_h[j] !== (j == FRAME + 1))     bad_done++;
    end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL busy_ignore_tx: %0d wrong cycles, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL busy_ignore_busy: %0d wrong cycles, expected 0", bad_busy); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL busy_ignore_done: %0d wrong cycles, expected 0", bad_done); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    int bad_tx, bad_busy, bad_done;
    f = 11'b11010110100;  // 5A, parity 1
    watch(60, 0, 8'h5A, -1, 8'h00, 45);  // cycle 45 lies in data bit 3
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int j = 0; j < 60; j++) begin
      if (tx_h[j] !== ((j <= 45) ? exp_tx(j, 1, f) : 1'b1)) bad_tx++;
      if (busy_h[j] !== (j >= 1 && j <= 45)) bad_busy++;
      if (done_h[j] !== 1'b0) bad_done++;
    end
    n_checks++; if (tx_h[46] !== 1'b1)   begin n_fail++; $display("FAIL abort_tx: got %b expected 1", tx_h[46]); end
    n_checks++; if (busy_h[46] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_h[46]); end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL abort_tx_cycles: %0d wrong cycles, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL abort_busy_cycles: %0d wrong cycles, expected 0", bad_busy); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL abort_no_done: %0d done cycles, expected 0", bad_done); end
    watch(120, 0, 8'h5A, -1, 8'h00, -1);
    bad_tx = 0; bad_done = 0;
    for (int j = 0; j < 120; j++) begin
      if (tx_h[j] !== exp_tx(j, 1, f))    bad_tx++;
      if (done_h[j] !== (j == FRAME + 1)) bad_done++;
    end
    n_checks++; if (bad_tx != 0)   begin n_fail++; $display("FAIL resend_tx_cycles: %0d wrong cycles, expected 0", bad_tx); end
    n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL resend_done: %0d wrong cycles, expected 0", bad_done); end
  endtask

  task automatic test_random_bytes();
    logic [7:0]  b, got;
    logic [10:0] f;
    int ones, bad_tx;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom_range(0, 255));
      ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      f = {1'b1, ((ones % 2) == 0), b, 1'b0};
      watch(115, 0, b, -1, 8'h00, -1);
      for (int i = 0; i < 8; i++) got[i] = tx_h[1 + (i + 1)*BC + BC/2];
      n_checks++; if (got !== b) begin n_fail++; $display("FAIL rand_byte%0d: got %h expected %h", n, got, b); end
      n_checks++;
      if (tx_h[1 + 9*BC + BC/2] !== f[9]) begin
        n_fail++; $display("FAIL rand_parity%0d: got %b expected %b", n, tx_h[1 + 9*BC + BC/2], f[9]);
      end
      bad_tx = 0;
      for (int j = 0; j < 115; j++) if (tx_h[j] !== exp_tx(j, 1, f)) bad_tx++;
      n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL rand_tx_cycles%0d: %0d wrong cycles, expected 0", n, bad_tx); end
    end
  endtask

`ifdef TX_PARITY_INJECT_EN
  task automatic test_parity_inject();
    logic [10:0] fi, fn;
    int bad_tx;
    fi = 11'b10101001010;  // A5 with inverted parity
    fn = 11'b11101001010;
    force_parity_err = 1'b1;
    watch(115, 0, 8'hA5, -1, 8'h00, -1);
    force_parity_err = 1'b0;
    bad_tx = 0;
    for (int j = 0; j < 115; j++) if (tx_h[j] !== exp_tx(j, 1, fi)) bad_tx++;
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL inject_tx_cycles: %0d wrong cycles, expected 0", bad_tx); end
    watch(115, 0, 8'hA5, -1, 8'h00, -1);
    bad_tx = 0;
    for (int j = 0; j < 115; j++) if (tx_h[j] !== exp_tx(j, 1, fn)) bad_tx++;
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL inject_one_frame_only: %0d wrong cycles, expected 0", bad_tx); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_send_while_busy();
    test_reset_mid_frame();
    test_random_bytes();
`ifdef TX_PARITY_INJECT_EN
    test_parity_inject();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
